// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, FSM states, helpers.
package alu_share_arbiter_pkg;

    localparam int unsigned OpcW  = 6;
    localparam int unsigned DataW = 32;

    // ALU opcodes; the arbiter passes them through unchecked.
    localparam logic [OpcW-1:0] OpAdd   = 6'h20;
    localparam logic [OpcW-1:0] OpAddu  = 6'h21;
    localparam logic [OpcW-1:0] OpSub   = 6'h22;
    localparam logic [OpcW-1:0] OpSubu  = 6'h23;
    localparam logic [OpcW-1:0] OpAnd   = 6'h24;
    localparam logic [OpcW-1:0] OpOr    = 6'h25;
    localparam logic [OpcW-1:0] OpXor   = 6'h26;
    localparam logic [OpcW-1:0] OpNor   = 6'h27;
    localparam logic [OpcW-1:0] OpSlt   = 6'h2A;
    localparam logic [OpcW-1:0] OpSltu  = 6'h2B;
    localparam logic [OpcW-1:0] OpLui   = 6'h0F;
    localparam logic [OpcW-1:0] OpSltiu = 6'h0B;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational requester picker: one-hot grant plus index.
// ALU_ARB_FIXED_PRI_EN selects lowest-index-wins; otherwise search starts after ptr_i.
module alu_share_arbiter_rr_picker
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_oh_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);

    assign any_o = |valid_i;

`ifdef ALU_ARB_FIXED_PRI_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Lowest set index wins.
    always_comb begin
        logic found;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && valid_i[IdxW'(i)]) begin
                found                = 1'b1;
                gnt_oh_o[IdxW'(i)]   = 1'b1;
                gnt_idx_o            = IdxW'(i);
            end
        end
    end
`else
    // First set bit searching ptr+1, ptr+2, ... modulo N.
    always_comb begin
        logic            found;
        logic [IdxW-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IdxW'((32'(ptr_i) + k) % N);
            if (!found && valid_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N requesters: accept, execute one cycle,
// hold the result until the winner takes it. ALU_ARB_FIXED_PRI_EN swaps
// round-robin for fixed lowest-index priority (no rotating pointer then).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = DataW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [OpcW*N-1:0] req_opcode,
    input  logic [W*N-1:0]    req_op1,
    input  logic [W*N-1:0]    req_op2,
    output logic [OpcW-1:0]   alu_opcode,
    output logic [W-1:0]      alu_op1,
    output logic [W-1:0]      alu_op2,
    input  logic [W-1:0]      alu_out,
    input  logic              alu_zero,
    output logic [N-1:0]      rsp_valid,
    input  logic [N-1:0]      rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_zero,
    output logic              busy
);

    localparam int unsigned IdxW = idx_width(N);

    state_e            state_q, state_d;
    logic [OpcW-1:0]   opc_q;
    logic [W-1:0]      op1_q, op2_q;
    logic [IdxW-1:0]   gnt_q;
    logic [W-1:0]      rsp_data_q;
    logic              rsp_zero_q;
    logic [IdxW-1:0]   rr_ptr;
    logic [N-1:0]      pick_oh;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic              gnt_rsp_ready;
    logic              accept_en;
    logic              accept;
    logic [OpcW-1:0]   sel_opc;
    logic [W-1:0]      sel_op1, sel_op2;

    alu_share_arbiter_rr_picker #(
        .N (N)
    ) u_picker (
        .valid_i   (req_valid),
        .ptr_i     (rr_ptr),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

`ifdef ALU_ARB_FIXED_PRI_EN
    assign rr_ptr = '0;
`else
    logic [IdxW-1:0] rr_ptr_q;

    // Last winner; reset to N-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= IdxW'(N - 1);
        end else if (accept) begin
            rr_ptr_q <= pick_idx;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // Response handshake of the current winner and its one-hot rsp_valid.
    always_comb begin
        gnt_rsp_ready = 1'b0;
        rsp_valid     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_q == IdxW'(i)) begin
                gnt_rsp_ready = rsp_ready[i];
                rsp_valid[i]  = (state_q == StResp);
            end
        end
    end

    // Operand mux driven by the picker's one-hot grant.
    always_comb begin
        sel_opc = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                sel_opc = req_opcode[OpcW*i +: OpcW];
                sel_op1 = req_op1[W*i +: W];
                sel_op2 = req_op2[W*i +: W];
            end
        end
    end

    assign accept_en = (state_q == StIdle) || ((state_q == StResp) && gnt_rsp_ready);
    assign accept    = accept_en && pick_any;
    assign req_ready = accept_en ? pick_oh : '0;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_any) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (gnt_rsp_ready) state_d = pick_any ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, latched request and captured ALU result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            opc_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            gnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opc_q <= sel_opc;
                op1_q <= sel_op1;
                op2_q <= sel_op2;
                gnt_q <= pick_idx;
            end
            if (state_q == StExec) begin
                rsp_data_q <= alu_out;
                rsp_zero_q <= alu_zero;
            end
        end
    end

    // ALU inputs are only live during EXEC.
    always_comb begin
        alu_opcode = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        if (state_q == StExec) begin
            alu_opcode = opc_q;
            alu_op1    = op1_q;
            alu_op2    = op2_q;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_zero = rsp_zero_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: bench-side ALU, transaction-level model checked
// every cycle, plus directed literal checks.
module tb_alu_share_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [6*N-1:0]  req_opcode;
    logic [32*N-1:0] req_op1;
    logic [32*N-1:0] req_op2;
    logic [5:0]    alu_opcode;
    logic [31:0]   alu_op1, alu_op2, alu_out;
    logic          alu_zero;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_zero;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    bit chk_en  = 1'b0;

    int acc_who[$];
    int acc_cyc[$];

    // Model state: one outstanding transaction at most.
    bit          m_pend;
    int          m_who;
    int          m_age;
    int          m_last;
    logic [5:0]  m_opc;
    logic [31:0] m_a, m_b, m_res;
    logic        m_zero;

    alu_share_arbiter #(.N(N), .W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return {31'd0, $signed(a) < $signed(b)};
            6'h2B, 6'h0B: return {31'd0, a < b};
            6'h0F: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_opcode, alu_op1, alu_op2);
    assign alu_zero = (alu_out == 32'd0);

    // Winner among valid requesters given the last winner; -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRI_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // Per-cycle compare against the model, then advance it by one clock.
    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                m_pend = 1'b0;
                m_last = N - 1;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
                chk("rst_alu_opcode", {26'd0, alu_opcode}, 32'd0);
                chk("rst_rsp_data", rsp_data, 32'd0);
            end else begin
                bit          can_acc;
                int          w;
                logic [N-1:0] exp_rdy, exp_rv;
                can_acc = !m_pend || (m_age >= 2 && rsp_ready[m_who]);
                w       = can_acc ? pick(req_valid, m_last) : -1;
                exp_rdy = (w >= 0) ? N'(1 << w) : '0;
                exp_rv  = (m_pend && m_age >= 2) ? N'(1 << m_who) : '0;
                chk("m_req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
                chk("m_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rv});
                chk("m_busy", {31'd0, busy}, {31'd0, m_pend});
                if (m_pend && m_age == 1) begin
                    chk("m_alu_opcode", {26'd0, alu_opcode}, {26'd0, m_opc});
                    chk("m_alu_op1", alu_op1, m_a);
                    chk("m_alu_op2", alu_op2, m_b);
                end else begin
                    chk("m_alu_idle", alu_op1 | alu_op2 | {26'd0, alu_opcode}, 32'd0);
                end
                if (m_pend && m_age >= 2) begin
                    chk("m_rsp_data", rsp_data, m_res);
                    chk("m_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
                end
                if (m_pend) begin
                    if (m_age >= 2 && rsp_ready[m_who]) m_pend = 1'b0;
                    m_age++;
                end
                if (w >= 0) begin
                    m_pend = 1'b1;
                    m_who  = w;
                    m_age  = 1;
                    m_opc  = req_opcode[6*w +: 6];
                    m_a    = req_op1[32*w +: 32];
                    m_b    = req_op2[32*w +: 32];
                    m_res  = alu_fn(m_opc, m_a, m_b);
                    m_zero = (m_res == 32'd0);
                    m_last = w;
                    acc_who.push_back(w);
                    acc_cyc.push_back(cyc_cnt);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [5:0] opc, input logic [31:0] a,
                           input logic [31:0] b);
        req_opcode[6*i +: 6] = opc;
        req_op1[32*i +: 32]  = a;
        req_op2[32*i +: 32]  = b;
    endtask

    // One isolated op from IDLE with all rsp_ready high; literal expectations.
    task automatic single_op(input int who, input logic [5:0] opc, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ed, input logic ez);
        req_valid      = '0;
        req_valid[who] = 1'b1;
        set_req(who, opc, a, b);
        @(negedge clk);
        chk("op_req_ready", {30'd0, req_ready}, 32'(1 << who));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("op_alu_opcode", {26'd0, alu_opcode}, {26'd0, opc});
        chk("op_alu_op1", alu_op1, a);
        @(negedge clk);
        chk("op_rsp_valid", {30'd0, rsp_valid}, 32'(1 << who));
        chk("op_rsp_data", rsp_data, ed);
        chk("op_rsp_zero", {31'd0, rsp_zero}, {31'd0, ez});
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    localparam logic [5:0] OPS [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                        6'h26, 6'h27, 6'h2A, 6'h2B, 6'h0F, 6'h3F};

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_op1    = '0;
        req_op2    = '0;
        rsp_ready  = '1;
        m_pend     = 1'b0;
        m_last     = N - 1;
        chk_en     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Single ops and compare/lui corner cases.
        single_op(0, 6'h20, 32'd3, 32'd5, 32'd8, 1'b0);
        single_op(0, 6'h22, 32'd7, 32'd7, 32'd0, 1'b1);
        single_op(0, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        single_op(0, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        single_op(0, 6'h0F, 32'd0, 32'h1234, 32'h1234_0000, 1'b0);
        single_op(1, 6'h3F, 32'd9, 32'd9, 32'd0, 1'b1);

        // Reset while an op from requester 1 is in EXEC.
        req_valid = 2'b10;
        set_req(1, 6'h20, 32'd1, 32'd2);
        @(posedge clk); #1;
        req_valid = '0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        idle_cycles(3);
        req_valid = 2'b11;
        set_req(0, 6'h20, 32'd4, 32'd4);
        @(negedge clk);
        chk("rst_first_gnt", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(3);

        // Hold off requester 1's response while requester 0 waits.
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        set_req(1, 6'h20, 32'd10, 32'd20);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        req_valid = 2'b01;
        set_req(0, 6'h24, 32'hF0, 32'h3C);
        repeat (5) begin
            @(negedge clk);
            chk("hold_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            chk("hold_rsp_data", rsp_data, 32'd30);
            chk("hold_rsp_zero", {31'd0, rsp_zero}, 32'd0);
            chk("hold_no_accept", {30'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("hold_release_accept", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(3);

        // Both requesters valid continuously.
        acc_who.delete();
        acc_cyc.delete();
        set_req(0, 6'h20, 32'd100, 32'd1);
        set_req(1, 6'h22, 32'd100, 32'd1);
        req_valid = 2'b11;
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(3);
        chk("both_accept_count", 32'(acc_who.size()), 32'd6);
        for (int i = 0; i < acc_who.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            chk("both_winner", 32'(acc_who[i]), 32'd0);
`else
            // Requester 0 won last, so requester 1 leads the alternation.
            chk("both_winner", 32'(acc_who[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
            if (i > 0) chk("both_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end

        // Random traffic, including dropped requests, stalls and resets.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [31:0] a, b;
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                set_req(i, OPS[$urandom_range(0, 11)], a, b);
                req_valid[i] = ($urandom_range(0, 2) != 0);
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        idle_cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
